// File: rtl/pconv_pkg.sv
// Shared definitions for the pointwise-convolution layer controller:
// FSM state encoding, group-select width and a clog2-based width helper.
package pconv_pkg;

  // Layer sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Width of the weight/bias/shift ROM group select
  localparam int GRP_W = 8;

  // Bits needed to hold every value 0..max_val inclusive
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pconv_credit.sv
// Downstream credit counter. Starts full at MAX, decrements when a pixel is
// issued and increments when the consumer frees a slot. A simultaneous
// increment and decrement leaves the count unchanged. The decrement is
// refused at zero; the caller masks increments that would pass MAX.
module pconv_credit
  import pconv_pkg::*;
#(
  parameter int MAX = 8,
  parameter int CW  = cnt_w(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] r_count;
  logic          w_dec_ok;

  assign w_dec_ok = dec && (r_count != '0);

  // Credit register: reset to full, move by at most one per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= CW'(MAX);
    end else if (inc && !w_dec_ok) begin
      r_count <= r_count + 1'b1;
    end else if (w_dec_ok && !inc) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/pconv_ctrl.sv
// Pointwise-convolution layer controller. Sequences OUT_GROUPS output-channel
// groups over one external pointwise datapath: for each group it issues the
// P = INPUT_SIZE^2 input pixels under downstream credit flow control, waits
// for P datapath results, then moves to the next group.
// Optional build macro: PCONV_CTRL_PERF_EN adds the 32-bit stall_cnt output
// counting RUN cycles spent with no downstream credit.
module pconv_ctrl
  import pconv_pkg::*;
#(
  parameter int INPUT_SIZE = 6,
  parameter int OUT_GROUPS = 2,
  parameter int CREDITS    = 8,
  parameter int AW         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pix_addr,
  output logic             pix_rd,
  output logic [GRP_W-1:0] grp_idx,
  output logic             dp_ce,
  output logic             dp_in_vld,
  input  logic             dp_out_vld,
  input  logic             credit_ret,
  output logic             grp_done
`ifdef PCONV_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int P  = INPUT_SIZE * INPUT_SIZE;
  localparam int CW = cnt_w(CREDITS);
  localparam int RW = cnt_w(P);

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_iss;
  logic [RW-1:0]    r_rcv;
  logic [GRP_W-1:0] r_grp;
  logic             r_in_vld;

  logic [CW-1:0]    w_credit_cnt;
  logic             w_credit_zero;
  logic             w_ret_ok;
  logic             w_pix_rd;
  logic             w_last_iss;
  logic             w_rcv_full;
  logic             w_last_grp;
  logic             w_start_ok;

  assign w_last_iss = (r_iss == AW'(P - 1));
  assign w_rcv_full = (r_rcv == RW'(P));
  assign w_last_grp = (r_grp == GRP_W'(OUT_GROUPS - 1));
  assign w_start_ok = (r_state == ST_IDLE) && start;

  // A slot return with all credits already home is spurious and dropped,
  // unless an issue in the same cycle consumes a credit, in which case the
  // pair cancels and the count stays at its ceiling.
  assign w_ret_ok = credit_ret && ((w_credit_cnt != CW'(CREDITS)) || w_pix_rd);

  pconv_credit #(
    .MAX (CREDITS),
    .CW  (CW)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ret_ok),
    .dec   (w_pix_rd),
    .count (w_credit_cnt),
    .zero  (w_credit_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_pix_rd && w_last_iss) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_rcv_full) begin
          w_state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_state_next = w_last_grp ? ST_FIN : ST_LOAD;
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs; a pixel is read only in RUN with a credit in hand
  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_FIN);
    grp_done = (r_state == ST_NEXT);
    dp_ce    = (r_state == ST_RUN) || (r_state == ST_DRAIN) ||
               (r_state == ST_NEXT);
    w_pix_rd = (r_state == ST_RUN) && !w_credit_zero;
  end

  // Issue/receive counters, group index and read-valid pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss    <= '0;
      r_rcv    <= '0;
      r_grp    <= '0;
      r_in_vld <= 1'b0;
    end else begin
      // Input buffer has one cycle of read latency
      r_in_vld <= w_pix_rd;

      if (w_start_ok) begin
        r_grp <= '0;
      end else if ((r_state == ST_NEXT) && !w_last_grp) begin
        r_grp <= r_grp + 1'b1;
      end

      if ((r_state == ST_NEXT) || (r_state == ST_LOAD)) begin
        r_iss <= '0;
      end else if (w_pix_rd && !w_last_iss) begin
        r_iss <= r_iss + 1'b1;
      end

      // Results only count while the datapath is enabled
      if ((r_state == ST_NEXT) || (r_state == ST_LOAD)) begin
        r_rcv <= '0;
      end else if (dp_ce && dp_out_vld && !w_rcv_full) begin
        r_rcv <= r_rcv + 1'b1;
      end
    end
  end

  assign pix_rd    = w_pix_rd;
  assign pix_addr  = r_iss;
  assign grp_idx   = r_grp;
  assign dp_in_vld = r_in_vld;

`ifdef PCONV_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  // Credit-starved RUN cycles, restarted per layer, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && w_credit_zero && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pconv_ctrl.sv
// Directed bench for pconv_ctrl with default parameters (6x6 map, 2 groups,
// 8 credits). A small datapath model returns results a few cycles after
// dp_in_vld; credit returns come either mirrored from pix_rd or manual.
// Build with PCONV_CTRL_PERF_EN defined to also exercise stall_cnt.
module tb_pconv_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [5:0] pix_addr;
  logic       pix_rd;
  logic [7:0] grp_idx;
  logic       dp_ce;
  logic       dp_in_vld;
  logic       dp_out_vld;
  logic       credit_ret;
  logic       grp_done;
`ifdef PCONV_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  // Credit return: mirrored issue (auto) or manual drive
  logic auto_ret;
  logic man_ret;
  logic ret_q;
  assign credit_ret = (auto_ret & ret_q) | man_ret;

  pconv_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pix_addr   (pix_addr),
    .pix_rd     (pix_rd),
    .grp_idx    (grp_idx),
    .dp_ce      (dp_ce),
    .dp_in_vld  (dp_in_vld),
    .dp_out_vld (dp_out_vld),
    .credit_ret (credit_ret),
    .grp_done   (grp_done)
`ifdef PCONV_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Monitor / environment state, written only by the monitor process
  int       n_rd = 0;
  int       n_gd = 0;
  int       n_done = 0;
  int       n_load = 0;
  int       addr_err = 0;
  int       exp_addr = 0;
  int       gd_idx_prev = 0;
  int       gd_idx_last = 0;
  int       gd_rd_prev = 0;
  int       gd_rd_last = 0;
  logic [3:0] pipe = '0;

  // Datapath model, credit mirror and event counters, all at the falling edge
  initial begin
    dp_out_vld = 1'b0;
    ret_q      = 1'b0;
    forever begin
      @(negedge clk);
      pipe       = {pipe[2:0], dp_in_vld};
      dp_out_vld = pipe[3];
      ret_q      = pix_rd;
      if (!rst_n) begin
        exp_addr = 0;
      end else begin
        if (busy && !dp_ce && !done) begin
          n_load++;
          exp_addr = 0;
        end
        if (pix_rd) begin
          if (int'(pix_addr) != exp_addr) addr_err++;
          exp_addr++;
          n_rd++;
        end
        if (grp_done) begin
          n_gd++;
          gd_idx_prev = gd_idx_last;
          gd_idx_last = int'(grp_idx);
          gd_rd_prev  = gd_rd_last;
          gd_rd_last  = n_rd;
        end
        if (done) n_done++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int d0;
    d0 = n_done;
    for (int i = 0; i < max_cyc; i++) begin
      cyc(1);
      if (n_done != d0) break;
    end
    chk(tag, n_done - d0, 1);
  endtask

  int base_rd;
  int base_gd;
  int base_load;
  int base_done;
  int base_aerr;
  int found;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    auto_ret = 1'b0;
    man_ret  = 1'b0;
    cyc(3);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grp_done", grp_done, 0);
    chk("rst_pix_rd", pix_rd, 0);
    chk("rst_dp_in_vld", dp_in_vld, 0);
    chk("rst_dp_ce", dp_ce, 0);
    chk("rst_grp_idx", grp_idx, 0);
    chk("rst_pix_addr", pix_addr, 0);
    rst_n = 1'b1;
    cyc(2);

    // Full layer with immediate credit returns; a stray start mid-RUN
    auto_ret  = 1'b1;
    base_rd   = n_rd;
    base_gd   = n_gd;
    base_load = n_load;
    base_aerr = addr_err;
    pulse_start();
    cyc(5);
    chk("run_busy", busy, 1);
    chk("run_dp_ce", dp_ce, 1);
    pulse_start();
    wait_done("l1_done_seen", 2000);
    chk("l1_done_level", done, 1);
    chk("l1_rd_grp0", gd_rd_prev - base_rd, 36);
    chk("l1_rd_total", gd_rd_last - base_rd, 72);
    chk("l1_grp_done", n_gd - base_gd, 2);
    chk("l1_grp_idx_first", gd_idx_prev, 0);
    chk("l1_grp_idx_second", gd_idx_last, 1);
    chk("l1_load_cycles", n_load - base_load, 2);
    chk("l1_addr_errors", addr_err - base_aerr, 0);
    cyc(1);
    chk("l1_done_pulse_end", done, 0);
    chk("l1_idle_busy", busy, 0);
    chk("l1_grp_idx_hold", grp_idx, 1);
    chk("l1_rd_total_final", n_rd - base_rd, 72);

    // Credit exhaustion: no returns -> exactly CREDITS reads then stall
    auto_ret = 1'b0;
    base_rd  = n_rd;
    base_gd  = n_gd;
    pulse_start();
    cyc(30);
    chk("cr_rd_after_stall", n_rd - base_rd, 8);
    chk("cr_stall_pix_rd", pix_rd, 0);
    chk("cr_stall_busy", busy, 1);
    man_ret = 1'b1;
    cyc(1);
    man_ret = 1'b0;
    cyc(5);
    chk("cr_one_more_rd", n_rd - base_rd, 9);
    // Return coincident with issue at credit=1
    man_ret = 1'b1;
    cyc(1);
    chk("cr_c1_issue", pix_rd, 1);
    cyc(1);
    chk("cr_c1_kept", pix_rd, 1);
    man_ret = 1'b0;
    cyc(1);
    chk("cr_c0_stall", pix_rd, 0);
    chk("cr_rd_count", n_rd - base_rd, 11);
    man_ret = 1'b1;
    wait_done("cr_done_seen", 2000);
    chk("cr_rd_total", n_rd - base_rd, 72);
    chk("cr_grp_done", n_gd - base_gd, 2);
    cyc(2);
    man_ret = 1'b0;
    cyc(2);

`ifdef PCONV_CTRL_PERF_EN
    // Exactly 10 credit-starved RUN cycles before returns resume
    pulse_start();
    cyc(18);
    man_ret = 1'b1;
    wait_done("perf_done_seen", 2000);
    chk("perf_stall_cnt", stall_cnt, 10);
    cyc(2);
    man_ret = 1'b0;
    cyc(2);
`endif

    // Reset during group 1 DRAIN aborts with no done
    auto_ret  = 1'b1;
    base_done = n_done;
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      if ((grp_idx == 8'd1) && dp_ce && !pix_rd && !grp_done) begin
        found = 1;
        break;
      end
    end
    chk("ab_drain_reached", found, 1);
    rst_n = 1'b0;
    cyc(1);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_grp_done", grp_done, 0);
    chk("ab_pix_rd", pix_rd, 0);
    chk("ab_dp_in_vld", dp_in_vld, 0);
    chk("ab_dp_ce", dp_ce, 0);
    chk("ab_grp_idx", grp_idx, 0);
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
    chk("ab_no_done", n_done - base_done, 0);

    // Fresh layer after the abort
    base_rd   = n_rd;
    base_gd   = n_gd;
    base_load = n_load;
    pulse_start();
    wait_done("rs_done_seen", 2000);
    chk("rs_rd_total", n_rd - base_rd, 72);
    chk("rs_grp_done", n_gd - base_gd, 2);
    chk("rs_grp_idx_first", gd_idx_prev, 0);
    chk("rs_grp_idx_second", gd_idx_last, 1);
    chk("rs_load_cycles", n_load - base_load, 2);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pconv_ctrl.md
PCONV_CTRL -- requirements
Module: pconv_ctrl

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 6: feature-map side; pixels per group P = INPUT_SIZE*INPUT_SIZE.
REQ-002 SHALL have parameter OUT_GROUPS, default 2: output-channel groups time-multiplexed over one pointwise array.
REQ-003 SHALL have parameter CREDITS, default 8: downstream buffer depth, 1..255.
REQ-004 SHALL have parameter AW, default 6: pixel address width, required 2^AW >= P.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1, reset synchronous, active-low.
REQ-006 SHALL have ports: start in 1, layer start pulse; busy out 1; done out 1, one-cycle layer-complete pulse.
REQ-007 SHALL have ports: pix_addr out AW, input-buffer read address; pix_rd out 1, read strobe (1-cycle read latency).
REQ-008 SHALL have ports: grp_idx out 8, weight/bias/shift ROM group select; dp_ce out 1, datapath enable; dp_in_vld out 1, datapath input valid.
REQ-009 SHALL have ports: dp_out_vld in 1, datapath output valid; credit_ret in 1, downstream slot-freed pulse; grp_done out 1, one-cycle pulse per group.

Function
REQ-010 SHALL implement FSM IDLE, LOAD, RUN, DRAIN, NEXT, FIN.
REQ-011 IDLE: start=1 -> LOAD, grp_idx=0; start ignored in every other state.
REQ-012 LOAD: exactly one cycle with dp_ce=0 (clears datapath counters, lets ROM settle), -> RUN.
REQ-013 RUN: issue counter iss 0..P-1; pix_rd=1 with pix_addr=iss when credit>0; dp_in_vld = pix_rd delayed one cycle.
REQ-014 RUN: credit decrements on each pix_rd, increments on credit_ret; simultaneous issue and return leaves credit unchanged.
REQ-015 credit SHALL never exceed CREDITS or go below 0; credit_ret at credit==CREDITS is ignored.
REQ-016 RUN -> DRAIN on the cycle the pixel with iss=P-1 is issued.
REQ-017 Output counter rcv increments on dp_out_vld while dp_ce=1; DRAIN -> NEXT when rcv reaches P.
REQ-018 NEXT: grp_done=1 for one cycle, rcv and iss cleared; grp_idx<OUT_GROUPS-1 -> increment grp_idx, LOAD; else -> FIN.
REQ-019 FIN: done=1 for one cycle, -> IDLE; grp_idx holds its final value until the next start.
REQ-020 busy SHALL be 1 in every state except IDLE; dp_ce SHALL be 1 in RUN, DRAIN, NEXT.
REQ-021 dp_out_vld in IDLE, LOAD or FIN SHALL be ignored.
REQ-022 credit SHALL persist across groups and layers, since downstream slots outlive a group.

Reset
REQ-023 On rst_n=0 at a clock edge: state=IDLE, credit=CREDITS, iss=rcv=0, grp_idx=0.
REQ-024 On rst_n=0 at a clock edge: busy, done, grp_done, pix_rd, dp_in_vld, dp_ce all 0.
REQ-025 Reset mid-layer SHALL abort without a done pulse; the next start begins at group 0.

Configuration
REQ-026 With PCONV_CTRL_PERF_EN defined: output stall_cnt (32 bit) counts RUN cycles with credit==0, cleared on start, saturating at all-ones.
REQ-027 With PCONV_CTRL_PERF_EN undefined: no stall_cnt port and no counter logic.

Structure
REQ-028 Shared package pconv_pkg SHALL hold the FSM state encoding and the clog2-based width constants.
REQ-029 The credit counter SHALL be sub-module pconv_credit (inc, dec, count, zero flag).
REQ-030 The datapath, ROMs and input buffer SHALL stay external.

Verification
REQ-031 INPUT_SIZE=6, OUT_GROUPS=2, credit_ret immediate, datapath latency 4; start -> 36 pix_rd per group, 2 grp_done, done at end, grp_idx 0 then 1.
REQ-032 CREDITS=8, credit_ret held 0 -> exactly 8 pix_rd then stall; one credit_ret -> exactly one further pix_rd.
REQ-033 credit_ret coincident with pix_rd at credit=1 -> credit stays 1, issue continues.
REQ-034 rst_n=0 during group 1 DRAIN -> all outputs 0 next cycle, no done; new start completes 2 groups normally.
REQ-035 start pulsed during RUN -> no effect; exactly one LOAD cycle (dp_ce=0) precedes each group.
REQ-036 PCONV_CTRL_PERF_EN with 10 zero-credit RUN cycles -> stall_cnt=10 at done.
